// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and strobe sequencer that lets two
// requesters share the 16x4 single-port data RAM. Read data is captured
// into rdata and each completed op is acknowledged with a one-cycle done.
// Defining RAM_ARB_WR_VERIFY_EN adds a read-back check after every write
// and the wr_err output reporting a mismatch.

module ram_arbiter #(
    parameter int AW     = 4,
    parameter int DW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [DW-1:0] rdata,
    output logic          mem_cs,
    output logic          mem_wrt,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
`ifdef RAM_ARB_WR_VERIFY_EN
    ,
    output logic          wr_err
`endif
);

    // state  | meaning
    // IDLE   | waiting for req; arbitrate and latch the winner's op
    // ACCESS | single RAM strobe cycle (write or read)
    // WAIT   | RD_LAT cycles for read data; capture on the last one
    // VRD    | read-back strobe of the address just written (verify build)
    // VWAIT  | RD_LAT cycles for read-back data; compare on the last one
    // DONE   | done pulse to the winner, gnt still high, then IDLE

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_VRD    = 3'd4,
        S_VWAIT  = 3'd5
    } state_t;

    // RD_LAT is at most 3, so the wait counter needs two bits
    localparam int            CW       = 2;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);

    state_t        state;
    logic          win;
    logic          last;
    logic          lat_we;
    logic [CW-1:0] cnt;
    logic          arb_win;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        arb_win = req[1];
        if (req == 2'b11) begin
            arb_win = ~last;
        end
    end

    assign sel_addr  = arb_win ? addr1 : addr0;
    assign sel_wdata = arb_win ? wdata1 : wdata0;

    // done is the only unregistered output: decoded from DONE and the latched winner
    assign done = (state == S_DONE) ? (win ? 2'b10 : 2'b01) : 2'b00;

    // Sequencer: arbitration, RAM strobes, read capture and grant, all registered.
    // mem_addr/mem_din keep the latched op's values for the whole operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            win      <= 1'b0;
            last     <= 1'b1;
            lat_we   <= 1'b0;
            cnt      <= '0;
            gnt      <= 2'b00;
            rdata    <= '0;
            mem_cs   <= 1'b0;
            mem_wrt  <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
`ifdef RAM_ARB_WR_VERIFY_EN
            wr_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        win      <= arb_win;
                        last     <= arb_win;
                        lat_we   <= we[arb_win];
                        gnt      <= arb_win ? 2'b10 : 2'b01;
                        mem_cs   <= 1'b1;
                        mem_wrt  <= we[arb_win];
                        mem_rd   <= ~we[arb_win];
                        mem_addr <= sel_addr;
                        if (we[arb_win]) begin
                            mem_din <= sel_wdata;
                        end
`ifdef RAM_ARB_WR_VERIFY_EN
                        wr_err   <= 1'b0;
`endif
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_wrt <= 1'b0;
                    cnt     <= CNT_LOAD;
                    if (lat_we) begin
`ifdef RAM_ARB_WR_VERIFY_EN
                        mem_cs <= 1'b1;
                        mem_rd <= 1'b1;
                        state  <= S_VRD;
`else
                        mem_cs <= 1'b0;
                        mem_rd <= 1'b0;
                        state  <= S_DONE;
`endif
                    end else begin
                        mem_cs <= 1'b0;
                        mem_rd <= 1'b0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        rdata <= mem_dout;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef RAM_ARB_WR_VERIFY_EN
                S_VRD: begin
                    mem_cs <= 1'b0;
                    mem_rd <= 1'b0;
                    cnt    <= CNT_LOAD;
                    state  <= S_VWAIT;
                end
                S_VWAIT: begin
                    if (cnt == '0) begin
                        // mem_din still holds the written word
                        wr_err <= (mem_dout != mem_din);
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    gnt   <= 2'b00;
                    state <= S_IDLE;
                end
                default: begin
                    gnt     <= 2'b00;
                    mem_cs  <= 1'b0;
                    mem_wrt <= 1'b0;
                    mem_rd  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: instance A (RD_LAT=1) carries the directed and
// random scenarios, instance B (RD_LAT=3) the longer read latency.
// Each instance has a behavioural RAM whose read data is valid only in
// the one cycle RD_LAT cycles after the rd strobe. With
// RAM_ARB_WR_VERIFY_EN defined, the RAM of instance A has bit0 stuck at 0.

module tb_ram_arbiter;

    localparam int RLAT_A = 1;
    localparam int RLAT_B = 3;
`ifdef RAM_ARB_WR_VERIFY_EN
    localparam int         WLAT_A = 3 + RLAT_A;
    localparam int         WLAT_B = 3 + RLAT_B;
    localparam logic [3:0] MASK   = 4'hE;
`else
    localparam int         WLAT_A = 2;
    localparam int         WLAT_B = 2;
    localparam logic [3:0] MASK   = 4'hF;
`endif
    localparam int RDL_A = 2 + RLAT_A;
    localparam int RDL_B = 2 + RLAT_B;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [1:0] req = 2'b00, we = 2'b00;
    logic [3:0] addr0 = 4'd0, addr1 = 4'd0, wdata0 = 4'd0, wdata1 = 4'd0;
    logic [1:0] gnt, done;
    logic [3:0] rdata, mem_addr, mem_din, mem_dout;
    logic       mem_cs, mem_wrt, mem_rd;

    logic [1:0] req_b = 2'b00, we_b = 2'b00;
    logic [3:0] addr0_b = 4'd0, addr1_b = 4'd0, wdata0_b = 4'd0, wdata1_b = 4'd0;
    logic [1:0] gnt_b, done_b;
    logic [3:0] rdata_b, mem_addr_b, mem_din_b, mem_dout_b;
    logic       mem_cs_b, mem_wrt_b, mem_rd_b;

`ifdef RAM_ARB_WR_VERIFY_EN
    logic       wr_err, wr_err_b;
`endif

    logic [3:0] ram_a [16] = '{default: 4'h0};
    logic [3:0] ram_b [16] = '{default: 4'h0};
    logic [3:0] pa = 4'h0;
    logic [3:0] pb0 = 4'h0, pb1 = 4'h0, pb2 = 4'h0;

    logic [3:0] ref_a [16] = '{default: 4'h0};
    int         ref_last = 1;
    logic [3:0] ref_rdata = 4'h0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(4), .DW(4), .RD_LAT(RLAT_A)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt      (gnt),
        .done     (done),
        .rdata    (rdata),
        .mem_cs   (mem_cs),
        .mem_wrt  (mem_wrt),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
`ifdef RAM_ARB_WR_VERIFY_EN
        ,
        .wr_err   (wr_err)
`endif
    );

    ram_arbiter #(.AW(4), .DW(4), .RD_LAT(RLAT_B)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .req      (req_b),
        .we       (we_b),
        .addr0    (addr0_b),
        .addr1    (addr1_b),
        .wdata0   (wdata0_b),
        .wdata1   (wdata1_b),
        .gnt      (gnt_b),
        .done     (done_b),
        .rdata    (rdata_b),
        .mem_cs   (mem_cs_b),
        .mem_wrt  (mem_wrt_b),
        .mem_rd   (mem_rd_b),
        .mem_addr (mem_addr_b),
        .mem_din  (mem_din_b),
        .mem_dout (mem_dout_b)
`ifdef RAM_ARB_WR_VERIFY_EN
        ,
        .wr_err   (wr_err_b)
`endif
    );

    // RAM A: write on strobe, read data valid for exactly one cycle RLAT_A after rd
    always @(posedge clk) begin
        if (mem_cs && mem_wrt) ram_a[mem_addr] <= mem_din & MASK;
        pa <= (mem_cs && mem_rd) ? ram_a[mem_addr] : 4'($urandom);
    end
    assign mem_dout = pa;

    // RAM B: same, three-stage read pipeline
    always @(posedge clk) begin
        if (mem_cs_b && mem_wrt_b) ram_b[mem_addr_b] <= mem_din_b;
        pb0 <= (mem_cs_b && mem_rd_b) ? ram_b[mem_addr_b] : 4'($urandom);
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign mem_dout_b = pb2;

    function automatic logic [1:0] oh(input int w);
        return (w != 0) ? 2'b10 : 2'b01;
    endfunction

    // Spec rule: lone requester wins; on a tie the one not served last wins
    function automatic int ref_pick(input logic [1:0] r);
        if (r == 2'b11) return (ref_last == 0) ? 1 : 0;
        return r[1] ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({gnt, done, rdata, mem_cs, mem_wrt, mem_rd, mem_addr, mem_din} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs_a: got %h expected 0", {gnt, done, rdata, mem_cs, mem_wrt, mem_rd, mem_addr, mem_din});
        end
        n_cmp++;
        if ({gnt_b, done_b, rdata_b, mem_cs_b, mem_wrt_b, mem_rd_b, mem_addr_b, mem_din_b} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs_b: got %h expected 0", {gnt_b, done_b, rdata_b, mem_cs_b, mem_wrt_b, mem_rd_b, mem_addr_b, mem_din_b});
        end
        rst = 1'b1;
        ref_last = 1;
        ref_rdata = 4'h0;
    endtask

    task automatic test_write();
        tick();
        req = 2'b01; we = 2'b01; addr0 = 4'd3; wdata0 = 4'd7;
        tick();
        n_cmp++;
        if ({gnt, mem_cs, mem_wrt, mem_rd, done} !== {2'b01, 3'b110, 2'b00}) begin
            n_err++;
            $display("FAIL write_access_strobes: got %b expected %b", {gnt, mem_cs, mem_wrt, mem_rd, done}, {2'b01, 3'b110, 2'b00});
        end
        n_cmp++;
        if ({mem_addr, mem_din} !== {4'd3, 4'd7}) begin
            n_err++;
            $display("FAIL write_access_addr_din: got %h expected 37", {mem_addr, mem_din});
        end
        for (int c = 2; c <= WLAT_A; c++) begin
            tick();
            if (c < WLAT_A) begin
                n_cmp++;
                if (done !== 2'b00) begin
                    n_err++;
                    $display("FAIL write_early_done: got %b expected 00 at n+%0d", done, c);
                end
            end
        end
        n_cmp++;
        if ({done, gnt, mem_cs, mem_wrt, mem_rd} !== {2'b01, 2'b01, 3'b000}) begin
            n_err++;
            $display("FAIL write_done: got %b expected %b", {done, gnt, mem_cs, mem_wrt, mem_rd}, {2'b01, 2'b01, 3'b000});
        end
        n_cmp++;
        if (rdata !== 4'd0) begin
            n_err++;
            $display("FAIL write_rdata_untouched: got %h expected 0", rdata);
        end
        req = 2'b00;
        ref_a[3] = 4'd7 & MASK;
        ref_last = 0;
    endtask

    task automatic test_read_back();
        tick();
        req = 2'b01; we = 2'b00; addr0 = 4'd3;
        tick();
        n_cmp++;
        if ({gnt, mem_cs, mem_wrt, mem_rd, mem_addr} !== {2'b01, 3'b101, 4'd3}) begin
            n_err++;
            $display("FAIL read_access: got %b expected %b", {gnt, mem_cs, mem_wrt, mem_rd, mem_addr}, {2'b01, 3'b101, 4'd3});
        end
        for (int c = 2; c <= RDL_A; c++) begin
            tick();
            if (c < RDL_A) begin
                n_cmp++;
                if ({done, mem_rd, mem_cs} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL read_wait: got %b expected 0000 at n+%0d", {done, mem_rd, mem_cs}, c);
                end
            end
        end
        n_cmp++;
        if (done !== 2'b01) begin
            n_err++;
            $display("FAIL read_done: got %b expected 01", done);
        end
        n_cmp++;
        if (rdata !== ref_a[3]) begin
            n_err++;
            $display("FAIL read_rdata: got %h expected %h", rdata, ref_a[3]);
        end
        ref_rdata = ref_a[3];
        req = 2'b00;
        ref_last = 0;
        // following write by requester 1 must leave rdata alone
        tick();
        req = 2'b10; we = 2'b10; addr1 = 4'd5; wdata1 = 4'd4;
        tick();
        n_cmp++;
        if ({gnt, mem_wrt, mem_addr, mem_din} !== {2'b10, 1'b1, 4'd5, 4'd4}) begin
            n_err++;
            $display("FAIL write1_access: got %h expected %h", {gnt, mem_wrt, mem_addr, mem_din}, {2'b10, 1'b1, 4'd5, 4'd4});
        end
        for (int c = 2; c <= WLAT_A; c++) tick();
        n_cmp++;
        if (done !== 2'b10) begin
            n_err++;
            $display("FAIL write1_done: got %b expected 10", done);
        end
        n_cmp++;
        if (rdata !== ref_rdata) begin
            n_err++;
            $display("FAIL rdata_held: got %h expected %h", rdata, ref_rdata);
        end
        req = 2'b00;
        ref_a[5] = 4'd4 & MASK;
        ref_last = 1;
    endtask

    task automatic test_contention();
        int         w;
        logic [3:0] ea;
        tick();
        req = 2'b11; we = 2'b00; addr0 = 4'd5; addr1 = 4'd3;
        for (int op = 0; op < 4; op++) begin
            w = op % 2;
            ea = (w != 0) ? 4'd3 : 4'd5;
            tick();
            n_cmp++;
            if ({gnt, mem_addr} !== {oh(w), ea}) begin
                n_err++;
                $display("FAIL contention_gnt op%0d: got %b expected %b", op, {gnt, mem_addr}, {oh(w), ea});
            end
            for (int c = 2; c <= RDL_A; c++) tick();
            n_cmp++;
            if ({done, rdata} !== {oh(w), ref_a[ea]}) begin
                n_err++;
                $display("FAIL contention_done op%0d: got %h expected %h", op, {done, rdata}, {oh(w), ref_a[ea]});
            end
            ref_last = w;
            ref_rdata = ref_a[ea];
            if (op == 3) req = 2'b00;
            else tick();
        end
    endtask

    task automatic test_drop_req();
        tick();
        req = 2'b01; we = 2'b00; addr0 = 4'd5;
        tick();
        tick();
        req = 2'b00; addr0 = 4'hF;
        for (int c = 3; c <= RDL_A; c++) tick();
        n_cmp++;
        if ({done, rdata} !== {2'b01, ref_a[5]}) begin
            n_err++;
            $display("FAIL drop_req_done: got %h expected %h", {done, rdata}, {2'b01, ref_a[5]});
        end
        ref_last = 0;
        ref_rdata = ref_a[5];
    endtask

    task automatic test_reset_mid();
        tick();
        req = 2'b01; we = 2'b00; addr0 = 4'd3;
        tick();
        tick();
        #1;
        rst = 1'b0;
        req = 2'b00;
        #1;
        n_cmp++;
        if ({gnt, done, mem_cs, mem_wrt, mem_rd} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %b expected 0000000", {gnt, done, mem_cs, mem_wrt, mem_rd});
        end
        tick();
        rst = 1'b1;
        ref_last = 1;
        ref_rdata = 4'h0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if ({gnt, done} !== 4'd0) begin
                n_err++;
                $display("FAIL reset_mid_no_done: got %b expected 0000 cycle %0d", {gnt, done}, c);
            end
        end
        n_cmp++;
        if (rdata !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid_rdata: got %h expected 0", rdata);
        end
    endtask

    task automatic test_random();
        logic [1:0] rq, wv;
        logic [3:0] a0, a1, d0, d1, ea, ed;
        logic       wr;
        int         w, lat;
        for (int i = 0; i < 40; i++) begin
            rq = 2'($urandom_range(1, 3));
            wv = 2'($urandom);
            a0 = 4'($urandom); a1 = 4'($urandom);
            d0 = 4'($urandom); d1 = 4'($urandom);
            w  = ref_pick(rq);
            wr = wv[w];
            ea = (w != 0) ? a1 : a0;
            ed = (w != 0) ? d1 : d0;
            lat = wr ? WLAT_A : RDL_A;
            tick();
            req = rq; we = wv; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
            tick();
            n_cmp++;
            if ({gnt, mem_cs, mem_wrt, mem_rd, mem_addr} !== {oh(w), 1'b1, wr, ~wr, ea}) begin
                n_err++;
                $display("FAIL rand_access i%0d: got %b expected %b", i, {gnt, mem_cs, mem_wrt, mem_rd, mem_addr}, {oh(w), 1'b1, wr, ~wr, ea});
            end
            if (wr) begin
                n_cmp++;
                if (mem_din !== ed) begin
                    n_err++;
                    $display("FAIL rand_din i%0d: got %h expected %h", i, mem_din, ed);
                end
            end
            addr0 = 4'($urandom); addr1 = 4'($urandom);
            wdata0 = 4'($urandom); wdata1 = 4'($urandom);
            ref_last = w;
            for (int c = 2; c <= lat; c++) begin
                tick();
                if (c < lat) begin
                    n_cmp++;
                    if (done !== 2'b00) begin
                        n_err++;
                        $display("FAIL rand_early_done i%0d: got %b expected 00 at n+%0d", i, done, c);
                    end
                end
            end
            if (!wr) ref_rdata = ref_a[ea];
            n_cmp++;
            if ({done, rdata} !== {oh(w), ref_rdata}) begin
                n_err++;
                $display("FAIL rand_done i%0d: got %h expected %h", i, {done, rdata}, {oh(w), ref_rdata});
            end
`ifdef RAM_ARB_WR_VERIFY_EN
            n_cmp++;
            if (wr_err !== (wr && ((ed & MASK) != ed))) begin
                n_err++;
                $display("FAIL rand_wr_err i%0d: got %b expected %b", i, wr_err, (wr && ((ed & MASK) != ed)));
            end
`endif
            if (wr) ref_a[ea] = ed & MASK;
            req = 2'b00;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_rd_lat3();
        int         rd_high;
        logic [3:0] exp_b;
        tick();
        req_b = 2'b01; we_b = 2'b01; addr0_b = 4'd6; wdata0_b = 4'd9;
        for (int c = 1; c <= WLAT_B; c++) tick();
        n_cmp++;
        if (done_b !== 2'b01) begin
            n_err++;
            $display("FAIL lat3_write_done: got %b expected 01", done_b);
        end
        req_b = 2'b00;
        exp_b = 4'd9;
        tick();
        req_b = 2'b01; we_b = 2'b00; addr0_b = 4'd6;
        rd_high = 0;
        for (int c = 1; c <= RDL_B; c++) begin
            tick();
            if (mem_rd_b === 1'b1) rd_high++;
            if (c == 1) begin
                n_cmp++;
                if ({gnt_b, mem_rd_b, mem_addr_b} !== {2'b01, 1'b1, 4'd6}) begin
                    n_err++;
                    $display("FAIL lat3_access: got %b expected %b", {gnt_b, mem_rd_b, mem_addr_b}, {2'b01, 1'b1, 4'd6});
                end
            end else if (c < RDL_B) begin
                n_cmp++;
                if (done_b !== 2'b00) begin
                    n_err++;
                    $display("FAIL lat3_early_done: got %b expected 00 at n+%0d", done_b, c);
                end
            end
        end
        n_cmp++;
        if ({done_b, rdata_b} !== {2'b01, exp_b}) begin
            n_err++;
            $display("FAIL lat3_done: got %h expected %h", {done_b, rdata_b}, {2'b01, exp_b});
        end
        n_cmp++;
        if (rd_high != 1) begin
            n_err++;
            $display("FAIL lat3_rd_pulse: got %0d cycles expected 1", rd_high);
        end
        req_b = 2'b00;
    endtask

`ifdef RAM_ARB_WR_VERIFY_EN
    task automatic test_wr_verify();
        logic [3:0] wd;
        for (int k = 0; k < 2; k++) begin
            wd = (k == 0) ? 4'd5 : 4'd4;
            tick();
            req = 2'b01; we = 2'b01; addr0 = 4'd2; wdata0 = wd;
            tick();
            n_cmp++;
            if ({mem_wrt, mem_rd, wr_err} !== 3'b100) begin
                n_err++;
                $display("FAIL verify_access k%0d: got %b expected 100", k, {mem_wrt, mem_rd, wr_err});
            end
            tick();
            n_cmp++;
            if ({mem_cs, mem_rd, mem_wrt, mem_addr} !== {3'b110, 4'd2}) begin
                n_err++;
                $display("FAIL verify_vrd k%0d: got %b expected %b", k, {mem_cs, mem_rd, mem_wrt, mem_addr}, {3'b110, 4'd2});
            end
            tick();
            n_cmp++;
            if ({mem_rd, done} !== 3'b000) begin
                n_err++;
                $display("FAIL verify_vwait k%0d: got %b expected 000", k, {mem_rd, done});
            end
            tick();
            n_cmp++;
            if ({done, wr_err} !== {2'b01, (k == 0)}) begin
                n_err++;
                $display("FAIL verify_done k%0d: got %b expected %b", k, {done, wr_err}, {2'b01, (k == 0)});
            end
            req = 2'b00;
            ref_a[2] = wd & MASK;
            ref_last = 0;
        end
        tick();
        req = 2'b01; we = 2'b00; addr0 = 4'd2;
        for (int c = 1; c <= RDL_A; c++) tick();
        n_cmp++;
        if ({done, rdata, wr_err} !== {2'b01, ref_a[2], 1'b0}) begin
            n_err++;
            $display("FAIL verify_read: got %h expected %h", {done, rdata, wr_err}, {2'b01, ref_a[2], 1'b0});
        end
        req = 2'b00;
        ref_rdata = ref_a[2];
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_back();
        test_contention();
        test_drop_req();
        test_reset_mid();
        test_random();
        test_rd_lat3();
`ifdef RAM_ARB_WR_VERIFY_EN
        test_wr_verify();
`endif
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
